// File: rtl/mole_pkg.sv
// Shared encodings for the whack-a-mole hole array and the spawn scheduler.
// Hole states are packed two bits per hole; only MOLE_IDLE means the hole can take a spawn.
package mole_pkg;

    localparam int NUM_MOLES = 16;

    localparam logic [1:0] MOLE_IDLE    = 2'b00;
    localparam logic [1:0] MOLE_RISING  = 2'b01;
    localparam logic [1:0] MOLE_UP      = 2'b10;
    localparam logic [1:0] MOLE_FALLING = 2'b11;

    // Galois mask for x^16 + x^14 + x^13 + x^11 + 1, right-shifting form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        SP_IDLE  = 2'd0,
        SP_COUNT = 2'd1,
        SP_PROBE = 2'd2,
        SP_FIRE  = 2'd3
    } spawner_state_t;

    function automatic logic [4:0] count_active(input logic [2*NUM_MOLES-1:0] states);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < NUM_MOLES; i++) begin
            if (states[2*i +: 2] != MOLE_IDLE) begin
                n = n + 5'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 16-bit Galois LFSR used to pick the first hole probed after each interval.
// Only the low nibble leaves the block since that is all the scheduler consumes.
module mole_lfsr
    import mole_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_step,
    output logic [3:0] o_index
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lfsr <= SEED;
        end else if (i_step) begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign o_index = r_lfsr[3:0];

endmodule

// File: rtl/mole_spawner.sv
// Spawn scheduler: counts down an interval, scans holes from a random start for an idle one,
// and emits a one-cycle one-hot start pulse. The interval shrinks as spawns accumulate.
//
//   state    | meaning
//   SP_IDLE  | game not running; counters and interval retained
//   SP_COUNT | waiting for the interval counter to reach zero
//   SP_PROBE | testing one hole per cycle for an idle slot
//   SP_FIRE  | emitting the start pulse and updating spawn/interval bookkeeping
module mole_spawner
    import mole_pkg::*;
#(
    parameter logic [5:0]  BASE_INTERVAL = 6'd24,
    parameter logic [5:0]  MIN_INTERVAL  = 6'd6,
    parameter logic [5:0]  RAMP_STEP     = 6'd2,
    parameter int          RAMP_EVERY    = 8,
    parameter int          MAX_ACTIVE    = 4,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        animation_clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        pause,
    input  logic [31:0] mole_states,
    output logic [15:0] start_moles,
    output logic [7:0]  spawn_count,
    output logic [7:0]  miss_count,
    output logic [5:0]  interval_now
);

    localparam logic [4:0] MAX_ACTIVE_L = 5'(MAX_ACTIVE);
    localparam logic [8:0] RAMP_EVERY_L = 9'(RAMP_EVERY);
    localparam logic [6:0] RAMP_FLOOR   = {1'b0, MIN_INTERVAL} + {1'b0, RAMP_STEP};

    spawner_state_t r_state;
    logic [5:0]     r_counter;
    logic [5:0]     r_interval;
    logic [3:0]     r_idx;
    logic [3:0]     r_probes;
    logic [3:0]     r_fire_idx;
    logic [15:0]    r_start;
    logic [7:0]     r_spawn;
    logic [7:0]     r_miss;

    logic [3:0]     w_lfsr_idx;
    logic [4:0]     w_active;
    logic           w_hole_idle;
    logic           w_at_max;
    logic [8:0]     w_spawn_inc;
    logic           w_ramp;
    logic [5:0]     w_interval_ramped;
    logic [7:0]     w_spawn_next;
    logic [7:0]     w_miss_next;

    mole_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (animation_clk),
        .rst     (rst),
        .i_step  (~pause),
        .o_index (w_lfsr_idx)
    );

    always_comb begin
        w_active    = count_active(mole_states);
        w_hole_idle = (mole_states[{r_idx, 1'b0} +: 2] == MOLE_IDLE);
        w_at_max    = (w_active >= MAX_ACTIVE_L);
    end

    // Ramp test uses the unsaturated successor so the period stays regular up to 255.
    always_comb begin
        w_spawn_inc       = {1'b0, r_spawn} + 9'd1;
        w_ramp            = ((w_spawn_inc % RAMP_EVERY_L) == 9'd0);
        w_interval_ramped = ({1'b0, r_interval} >= RAMP_FLOOR) ? (r_interval - RAMP_STEP)
                                                               : MIN_INTERVAL;
        w_spawn_next      = (r_spawn == 8'hFF) ? r_spawn : (r_spawn + 8'd1);
        w_miss_next       = (r_miss  == 8'hFF) ? r_miss  : (r_miss  + 8'd1);
    end

    always_ff @(posedge animation_clk) begin
        if (!rst) begin
            r_state    <= SP_IDLE;
            r_counter  <= BASE_INTERVAL;
            r_interval <= BASE_INTERVAL;
            r_idx      <= 4'd0;
            r_probes   <= 4'd0;
            r_fire_idx <= 4'd0;
            r_start    <= 16'h0000;
            r_spawn    <= 8'd0;
            r_miss     <= 8'd0;
        end else if (pause) begin
            // Clearing here keeps a pulse caught by pause from reappearing on resume.
            r_start <= 16'h0000;
        end else if (!enable) begin
            r_state <= SP_IDLE;
            r_start <= 16'h0000;
        end else begin
            r_start <= 16'h0000;
            case (r_state)
                SP_IDLE: begin
                    r_counter <= r_interval;
                    r_state   <= SP_COUNT;
                end
                SP_COUNT: begin
                    if (r_counter != 6'd0) begin
                        r_counter <= r_counter - 6'd1;
                    end else begin
                        r_idx    <= w_lfsr_idx;
                        r_probes <= 4'd0;
                        r_state  <= SP_PROBE;
                    end
                end
                SP_PROBE: begin
                    if (w_hole_idle && !w_at_max) begin
                        r_fire_idx <= r_idx;
                        r_state    <= SP_FIRE;
                    end else if (w_at_max || (r_probes == 4'd15)) begin
                        r_miss    <= w_miss_next;
                        r_counter <= r_interval;
                        r_state   <= SP_COUNT;
                    end else begin
                        r_idx    <= r_idx + 4'd1;
                        r_probes <= r_probes + 4'd1;
                    end
                end
                SP_FIRE: begin
                    r_start <= 16'h0001 << r_fire_idx;
                    r_spawn <= w_spawn_next;
                    if (w_ramp) begin
                        r_interval <= w_interval_ramped;
                        r_counter  <= w_interval_ramped;
                    end else begin
                        r_counter <= r_interval;
                    end
                    r_state <= SP_COUNT;
                end
                default: r_state <= SP_IDLE;
            endcase
        end
    end

    assign start_moles  = r_start & {16{~pause}};
    assign spawn_count  = r_spawn;
    assign miss_count   = r_miss;
    assign interval_now = r_interval;

endmodule

// File: tb/tb_mole_spawner.sv
// Self-checking bench for mole_spawner: directed scenarios plus a randomized run,
// all compared against an event-level scheduling model kept in this file.
module tb_mole_spawner;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        pause;
    logic [31:0] mole_states;
    logic [15:0] start_moles;
    logic [7:0]  spawn_count;
    logic [7:0]  miss_count;
    logic [5:0]  interval_now;

    int errors = 0;
    int checks = 0;

    mole_spawner dut (
        .animation_clk (clk),
        .rst           (rst),
        .enable        (enable),
        .pause         (pause),
        .mole_states   (mole_states),
        .start_moles   (start_moles),
        .spawn_count   (spawn_count),
        .miss_count    (miss_count),
        .interval_now  (interval_now)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    localparam int PH_STOP = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_SCAN = 2;
    localparam int PH_FIRE = 3;

    int          m_phase, m_wait, m_left, m_hole, m_interval, m_spawn, m_miss;
    logic [15:0] m_lfsr;
    logic [15:0] m_pulse;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        logic fb;
        fb = l[0];
        l  = l >> 1;
        if (fb) l = l ^ 16'hB400;
        return l;
    endfunction

    function automatic logic [3:0] predict_start(input logic [15:0] l, input int w);
        for (int k = 0; k < w; k++) l = lfsr_next(l);
        return l[3:0];
    endfunction

    // Whole probe outcome in one go: cycles spent probing and the chosen hole (-1 = miss).
    task automatic plan_probe(input logic [3:0] s, input logic [31:0] st,
                              output int left, output int hole);
        int busy;
        bit done;
        busy = 0;
        done = 0;
        left = 16;
        hole = -1;
        for (int i = 0; i < 16; i++) if (st[2*i +: 2] != 2'b00) busy++;
        if (busy >= 4) begin
            left = 1;
            done = 1;
        end
        for (int k = 0; k < 16; k++) begin
            if (!done && st[2*((s + k) % 16) +: 2] == 2'b00) begin
                left = k + 1;
                hole = (s + k) % 16;
                done = 1;
            end
        end
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            m_phase = PH_STOP; m_wait = 24; m_left = 0; m_hole = 0;
            m_interval = 24; m_spawn = 0; m_miss = 0;
            m_lfsr = 16'hACE1; m_pulse = 16'h0000;
        end else if (pause) begin
            m_pulse = 16'h0000;
        end else begin
            m_pulse = 16'h0000;
            if (!enable) begin
                m_phase = PH_STOP;
            end else begin
                case (m_phase)
                    PH_STOP: begin
                        m_phase = PH_WAIT;
                        m_wait  = m_interval;
                    end
                    PH_WAIT: begin
                        if (m_wait > 0) m_wait--;
                        else begin
                            plan_probe(m_lfsr[3:0], mole_states, m_left, m_hole);
                            m_phase = PH_SCAN;
                        end
                    end
                    PH_SCAN: begin
                        m_left--;
                        if (m_left == 0) begin
                            if (m_hole < 0) begin
                                if (m_miss < 255) m_miss++;
                                m_wait  = m_interval;
                                m_phase = PH_WAIT;
                            end else begin
                                m_phase = PH_FIRE;
                            end
                        end
                    end
                    default: begin
                        m_pulse = 16'h0001 << m_hole;
                        if ((m_spawn + 1) % 8 == 0)
                            m_interval = (m_interval - 2 < 6) ? 6 : m_interval - 2;
                        if (m_spawn < 255) m_spawn++;
                        m_wait  = m_interval;
                        m_phase = PH_WAIT;
                    end
                endcase
            end
            m_lfsr = lfsr_next(m_lfsr);
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0; enable = 1'b0; pause = 1'b0; mole_states = 32'h0;
        repeat (2) @(negedge clk);
        checks++; if (start_moles !== 16'h0) begin errors++; $display("FAIL reset_start got=%h want=0000", start_moles); end
        checks++; if (spawn_count !== 8'd0) begin errors++; $display("FAIL reset_spawn got=%0d want=0", spawn_count); end
        checks++; if (miss_count !== 8'd0) begin errors++; $display("FAIL reset_miss got=%0d want=0", miss_count); end
        checks++; if (interval_now !== 6'd24) begin errors++; $display("FAIL reset_interval got=%0d want=24", interval_now); end
    endtask

    task automatic test_first_spawn();
        logic [15:0] l;
        logic [15:0] exp;
        l = 16'hACE1;
        for (int k = 0; k < 25; k++) l = lfsr_next(l);
        exp = 16'h0001 << l[3:0];
        rst = 1'b1; enable = 1'b1; pause = 1'b0; mole_states = 32'h0;
        for (int i = 0; i <= 28; i++) begin
            @(negedge clk);
            if (i < 27) begin
                checks++; if (start_moles !== 16'h0) begin errors++; $display("FAIL first_early cyc=%0d got=%h want=0000", i, start_moles); end
            end else if (i == 27) begin
                checks++; if (start_moles !== exp) begin errors++; $display("FAIL first_pulse got=%h want=%h", start_moles, exp); end
                checks++; if (spawn_count !== 8'd1) begin errors++; $display("FAIL first_count got=%0d want=1", spawn_count); end
            end else begin
                checks++; if (start_moles !== 16'h0) begin errors++; $display("FAIL first_width got=%h want=0000", start_moles); end
            end
        end
    endtask

    task automatic test_probe_wrap();
        bit found;
        int w, s, got;
        found = 0; w = 0; s = 0; got = -1;
        for (int i = 0; i < 3000 && !found; i++) begin
            if (m_phase == PH_WAIT && predict_start(m_lfsr, m_wait) >= 4'd13) begin
                found = 1;
                w = m_wait;
                s = int'(predict_start(m_lfsr, m_wait));
                mole_states = 32'h0;
                for (int k = 0; k < 3; k++) mole_states[2*((s + k) % 16) +: 2] = 2'b01;
            end else begin
                @(negedge clk);
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL wrap_setup got=timeout want=start>=13"); end
        if (found) begin
            for (int j = 1; j <= 80 && got < 0; j++) begin
                @(negedge clk);
                if (start_moles !== 16'h0) begin
                    got = j;
                    checks++; if (start_moles !== (16'h0001 << ((s + 3) % 16)))
                        begin errors++; $display("FAIL wrap_hole got=%h want=hole%0d", start_moles, (s + 3) % 16); end
                end
            end
            checks++; if (got != w + 6) begin errors++; $display("FAIL wrap_delay got=%0d want=%0d", got, w + 6); end
        end
        mole_states = 32'h0;
    endtask

    task automatic test_max_active();
        int miss0, min_exp;
        bit quiet;
        for (int i = 0; i < 100 && m_phase != PH_WAIT; i++) @(negedge clk);
        mole_states = 32'h0;
        mole_states[1:0] = 2'b10; mole_states[11:10] = 2'b01;
        mole_states[21:20] = 2'b11; mole_states[31:30] = 2'b10;
        miss0 = m_miss;
        min_exp = 150 / (m_interval + 2) - 1;
        quiet = 1;
        repeat (150) begin
            @(negedge clk);
            if (start_moles !== 16'h0) quiet = 0;
        end
        checks++; if (!quiet) begin errors++; $display("FAIL maxact_pulse got=pulse want=none"); end
        checks++; if (miss_count !== 8'(m_miss)) begin errors++; $display("FAIL maxact_miss got=%0d want=%0d", miss_count, m_miss); end
        checks++; if (int'(miss_count) - miss0 < min_exp || int'(miss_count) == miss0)
            begin errors++; $display("FAIL maxact_rate got=%0d want>=%0d", int'(miss_count) - miss0, min_exp); end
        for (int i = 0; i < 100 && m_phase != PH_WAIT; i++) @(negedge clk);
        mole_states = 32'h0;
    endtask

    task automatic test_ramp();
        int tgt [4] = '{8, 64, 72, 80};
        int want [4] = '{22, 8, 6, 6};
        bit hit;
        rst = 1'b0; enable = 1'b0; pause = 1'b0; mole_states = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b1; enable = 1'b1;
        for (int t = 0; t < 4; t++) begin
            hit = 0;
            for (int i = 0; i < 3000 && !hit; i++) begin
                @(negedge clk);
                if (spawn_count == 8'(tgt[t])) hit = 1;
            end
            checks++;
            if (!hit) begin errors++; $display("FAIL ramp_wait%0d got=timeout want=spawn%0d", t, tgt[t]); end
            else if (interval_now !== 6'(want[t])) begin
                errors++; $display("FAIL ramp_interval%0d got=%0d want=%0d", t, interval_now, want[t]);
            end
        end
    endtask

    task automatic test_pause_fire();
        logic [15:0] exp;
        int sp0, mi0;
        for (int i = 0; i < 200 && m_phase != PH_FIRE; i++) @(negedge clk);
        checks++; if (m_phase != PH_FIRE) begin errors++; $display("FAIL pause_setup got=timeout want=fire"); end
        exp = 16'h0001 << m_hole;
        sp0 = m_spawn;
        mi0 = m_miss;
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (start_moles !== 16'h0) begin errors++; $display("FAIL pause_start cyc=%0d got=%h want=0000", i, start_moles); end
            checks++; if (spawn_count !== 8'(sp0) || miss_count !== 8'(mi0))
                begin errors++; $display("FAIL pause_frozen got=%0d/%0d want=%0d/%0d", spawn_count, miss_count, sp0, mi0); end
        end
        pause = 1'b0;
        @(negedge clk);
        checks++; if (start_moles !== exp) begin errors++; $display("FAIL pause_resume got=%h want=%h", start_moles, exp); end
        checks++; if (spawn_count !== 8'(sp0 + 1)) begin errors++; $display("FAIL pause_count got=%0d want=%0d", spawn_count, sp0 + 1); end
        @(negedge clk);
        checks++; if (start_moles !== 16'h0) begin errors++; $display("FAIL pause_width got=%h want=0000", start_moles); end
    endtask

    task automatic test_random();
        bit did_reset;
        logic [31:0] st;
        did_reset = 0;
        for (int i = 0; i < 3000; i++) begin
            rst    = 1'b1;
            pause  = ($urandom_range(0, 9) == 0);
            enable = ($urandom_range(0, 199) != 0);
            if (i > 1000 && !did_reset && m_phase == PH_FIRE) begin
                rst = 1'b0;
                did_reset = 1;
            end
            if (m_phase == PH_WAIT && $urandom_range(0, 3) == 0) begin
                st = 32'h0;
                for (int h = 0; h < 16; h++)
                    if ($urandom_range(0, 15) < 3) st[2*h +: 2] = 2'($urandom_range(1, 3));
                mole_states = st;
            end
            @(negedge clk);
            checks++; if (start_moles !== (pause ? 16'h0 : m_pulse))
                begin errors++; $display("FAIL rnd_start cyc=%0d got=%h want=%h", i, start_moles, pause ? 16'h0 : m_pulse); end
            checks++; if (spawn_count !== 8'(m_spawn)) begin errors++; $display("FAIL rnd_spawn cyc=%0d got=%0d want=%0d", i, spawn_count, m_spawn); end
            checks++; if (miss_count !== 8'(m_miss)) begin errors++; $display("FAIL rnd_miss cyc=%0d got=%0d want=%0d", i, miss_count, m_miss); end
            checks++; if (interval_now !== 6'(m_interval)) begin errors++; $display("FAIL rnd_interval cyc=%0d got=%0d want=%0d", i, interval_now, m_interval); end
            checks++; if ($countones(start_moles) > 1) begin errors++; $display("FAIL rnd_onehot cyc=%0d got=%h want=onehot", i, start_moles); end
        end
        checks++; if (!did_reset) begin errors++; $display("FAIL rnd_midfire_reset got=none want=applied"); end
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; pause = 1'b0; mole_states = 32'h0;
        @(negedge clk);
        test_reset();
        test_first_spawn();
        test_probe_wrap();
        test_max_active();
        test_ramp();
        test_pause_fire();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
